// File: rtl/ram_fifo_pkg.sv
// ----------------------------------------------------------------------------
// ram_fifo_pkg
//  Shared constants and types for the RAM-backed FIFO controller.
//  DATA_W_DEF / ADDR_W_DEF : default data and RAM address widths
//  DEPTH                   : number of RAM words (2**ADDR_W_DEF)
//  AF_LEVEL_DEF            : default almost-full threshold
//  ptr_t                   : pointer type with one extra wrap bit
// ----------------------------------------------------------------------------
package ram_fifo_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 6;
  localparam int DEPTH        = 1 << ADDR_W_DEF;
  localparam int AF_LEVEL_DEF = 56;

  // MSB is the wrap bit; it tells full apart from empty when the low bits match.
  typedef logic [ADDR_W_DEF:0] ptr_t;

endpackage

// File: rtl/ram_dual_port1.sv
// ----------------------------------------------------------------------------
// ram_dual_port1
//  Simple dual-port RAM, one write port and one read port with a registered
//  read (q is valid the cycle after read_addr is presented).
//  Ports:
//    data, write_addr, we, write_clk : write port
//    read_addr, read_clk, q          : read port (1-cycle registered read)
// ----------------------------------------------------------------------------
module ram_dual_port1 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              we,
  input  logic              read_clk,
  input  logic              write_clk,
  output logic [DATA_W-1:0] q
);

  // NOTE: the storage array has no reset so it maps onto block RAM; the
  // controller never presents an unwritten word as valid.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge write_clk) begin
    if (we) begin
      r_mem[write_addr] <= data;
    end
  end

  always_ff @(posedge read_clk) begin
    q <= r_mem[read_addr];
  end

endmodule

// File: rtl/ram_fifo_ptr.sv
// ----------------------------------------------------------------------------
// ram_fifo_ptr
//  Wrap-bit pointer register with synchronous clear and increment.
//  Used for both the write and the read pointer of the FIFO.
//  Ports:
//    clk, rst_n : clock, asynchronous active-low reset
//    i_clr      : synchronous clear to zero (wins over i_inc)
//    i_inc      : advance pointer by one, wrapping modulo 2**W
//    o_ptr      : current pointer value
// ----------------------------------------------------------------------------
module ram_fifo_ptr #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // NOTE: state is updated with non-blocking (<=) assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// ram_fifo_ctrl
//  Single-clock FIFO controller sequencing an external dual-port RAM with a
//  1-cycle registered read. Turns valid/ready push and pop streams into RAM
//  write/read addresses and write enable, tracks occupancy and flags, and
//  hides the read latency so a pop costs no extra cycle.
//  Ports:
//    clk, rst_n                 : clock, asynchronous active-low reset
//    flush                      : synchronous clear, overrides push/pop
//    in_data/in_valid/in_ready  : push stream
//    out_data/out_valid/out_ready : pop stream (out_data = ram_q)
//    count, full, empty, almost_full : occupancy and flags
//    ram_we, ram_write_addr, ram_data, ram_read_addr, ram_q : RAM side
// ----------------------------------------------------------------------------
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(AF_LEVEL);

  logic [ADDR_W:0] w_wr_ptr;
  logic [ADDR_W:0] w_rd_ptr;
  logic [ADDR_W:0] r_wr_vis;
  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;

  // Flag and handshake logic. flush blocks both directions in its cycle.
  assign w_count     = w_wr_ptr - w_rd_ptr;
  assign w_full      = (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]) &&
                       (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]);
  assign w_in_ready  = !w_full && !flush;
  assign w_push      = in_valid && w_in_ready;
  // Readers compare against the delayed write pointer: a word written at
  // edge N is only read from edge N+1 on, so a RAM read never races its write.
  assign w_out_valid = (r_wr_vis != w_rd_ptr);
  assign w_pop       = w_out_valid && out_ready && !flush;

  ram_fifo_ptr #(.W(ADDR_W + 1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  ram_fifo_ptr #(.W(ADDR_W + 1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_vis <= '0;
    end else if (flush) begin
      r_wr_vis <= '0;
    end else begin
      r_wr_vis <= w_wr_ptr;
    end
  end

  // Look one entry ahead on a pop so ram_q holds the new head next cycle.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    ram_read_addr = w_rd_ptr[ADDR_W-1:0];
    if (w_pop) begin
      ram_read_addr = w_rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
    end
  end

  assign ram_we         = w_push;
  assign ram_write_addr = w_wr_ptr[ADDR_W-1:0];
  assign ram_data       = in_data;

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = ram_q;
  assign count       = w_count;
  assign full        = w_full;
  assign empty       = (w_wr_ptr == w_rd_ptr);
  assign almost_full = (w_count >= AF_THRESH);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
//  Directed and randomized bench for ram_fifo_ctrl with the dual-port RAM.
// ----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       ram_we;
  logic [5:0] ram_write_addr;
  logic [7:0] ram_data;
  logic [5:0] ram_read_addr;
  logic [7:0] ram_q;

  int n_checks = 0;
  int n_errors = 0;

  ram_fifo_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_data       (ram_data),
    .ram_read_addr  (ram_read_addr),
    .ram_q          (ram_q)
  );

  ram_dual_port1 u_ram (
    .data       (ram_data),
    .read_addr  (ram_read_addr),
    .write_addr (ram_write_addr),
    .we         (ram_we),
    .read_clk   (clk),
    .write_clk  (clk),
    .q          (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (count !== 7'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    @(negedge clk) rst_n = 1'b1;
    next();
    // Traffic, then reset asserted mid-cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h30 + 8'(i);
      next();
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 7'd3) begin n_errors++; $display("FAIL pre_reset_count got=%0d exp=3", count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 7'd0) begin n_errors++; $display("FAIL midreset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL midreset_empty got=%b exp=1", empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    next();
  endtask

  task automatic test_single();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL single_ram_we got=%b exp=1", ram_we); end
    n_checks++; if (ram_write_addr !== 6'd0) begin n_errors++; $display("FAIL single_waddr got=%0d exp=0", ram_write_addr); end
    n_checks++; if (ram_data !== 8'hA5) begin n_errors++; $display("FAIL single_ram_data got=%h exp=a5", ram_data); end
    next();  // edge N
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_ov_N got=%b exp=0", out_valid); end
    n_checks++; if (count !== 7'd1) begin n_errors++; $display("FAIL single_count got=%0d exp=1", count); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL single_empty got=%b exp=0", empty); end
    next();  // edge N+1
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_ov_N1 got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 8'hA5) begin n_errors++; $display("FAIL single_data got=%h exp=a5", out_data); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (ram_read_addr !== 6'd1) begin n_errors++; $display("FAIL single_raddr got=%0d exp=1", ram_read_addr); end
    next();
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_pop_ov got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill_drain();
    logic exp_af;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'(i);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL fill_in_ready i=%0d got=%b exp=1", i, in_ready); end
      next();
      exp_af = ((i + 1) >= 56);
      n_checks++; if (count !== 7'(i + 1)) begin n_errors++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
      n_checks++; if (almost_full !== exp_af) begin n_errors++; $display("FAIL fill_af count=%0d got=%b exp=%b", i + 1, almost_full, exp_af); end
    end
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL fill_full got=%b exp=1", full); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_in_ready_full got=%b exp=0", in_ready); end
    // 65th push alongside a pop: push must be refused.
    in_data   = 8'hFF;
    out_ready = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL full_push_we got=%b exp=0", ram_we); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL drain_data i=0 got=%h exp=00", out_data); end
    next();
    in_valid = 1'b0;
    n_checks++; if (count !== 7'd63) begin n_errors++; $display("FAIL full_pop_count got=%0d exp=63", count); end
    for (int i = 1; i < DEPTH; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL drain_ov i=%0d got=%b exp=1", i, out_valid); end
      n_checks++; if (out_data !== 8'(i)) begin n_errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, out_data, 8'(i)); end
      next();
    end
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_ov_end got=%b exp=0", out_valid); end
    n_checks++; if (almost_full !== 1'b0) begin n_errors++; $display("FAIL drain_af got=%b exp=0", almost_full); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] v;
    v = 8'h80;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = v;
      q.push_back(v);
      v++;
      next();
    end
    in_valid = 1'b0;
    next();
    next();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      in_data = v;
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_ov c=%0d got=%b exp=1", c, out_valid); end
      n_checks++; if (out_data !== q[0]) begin n_errors++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, out_data, q[0]); end
      next();
      void'(q.pop_front());
      q.push_back(v);
      v++;
      n_checks++; if (count !== 7'd5) begin n_errors++; $display("FAIL stream_count c=%0d got=%0d exp=5", c, count); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_drain_ov k=%0d got=%b exp=1", k, out_valid); end
      n_checks++; if (out_data !== q[0]) begin n_errors++; $display("FAIL stream_drain_data k=%0d got=%h exp=%h", k, out_data, q[0]); end
      next();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL stream_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h10 + 8'(i);
      next();
    end
    in_data   = 8'hEE;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    n_checks++; if (count !== 7'd10) begin n_errors++; $display("FAIL flush_pre_count got=%0d exp=10", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL flush_ram_we got=%b exp=0", ram_we); end
    next();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (count !== 7'd0) begin n_errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_ov got=%b exp=0", out_valid); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
    // FIFO is usable straight after a flush.
    in_data  = 8'h77;
    in_valid = 1'b1;
    next();
    in_valid = 1'b0;
    next();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL post_flush_ov got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 8'h77) begin n_errors++; $display("FAIL post_flush_data got=%h exp=77", out_data); end
    out_ready = 1'b1;
    next();
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL post_flush_empty got=%b exp=1", empty); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       last_push;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic       do_push;
    logic       do_pop;
    int         vis;
    int         pv;
    int         pr;
    last_push = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      // Alternate fill-biased and drain-biased phases so both flags get hit.
      pv = ((c / 1000) % 2 == 0) ? 85 : 35;
      pr = ((c / 1000) % 2 == 0) ? 30 : 85;
      in_valid  = ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      in_data   = 8'($urandom_range(0, 255));
      #1;
      vis           = q.size() - (last_push ? 1 : 0);
      exp_in_ready  = (q.size() < DEPTH);
      exp_out_valid = (vis > 0);
      n_checks++; if (count !== 7'(q.size())) begin n_errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, q.size()); end
      n_checks++; if (full !== (q.size() == DEPTH)) begin n_errors++; $display("FAIL rand_full c=%0d got=%b", c, full); end
      n_checks++; if (almost_full !== (q.size() >= 56)) begin n_errors++; $display("FAIL rand_af c=%0d got=%b", c, almost_full); end
      n_checks++; if (in_ready !== exp_in_ready) begin n_errors++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_in_ready); end
      n_checks++; if (out_valid !== exp_out_valid) begin n_errors++; $display("FAIL rand_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_out_valid); end
      do_push = in_valid && exp_in_ready;
      do_pop  = out_ready && exp_out_valid;
      if (do_pop) begin
        n_checks++; if (out_data !== q[0]) begin n_errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, q[0]); end
      end
      next();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
      last_push = do_push;
      if (n_errors > 50) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
